// File: rtl/tl_probe_engine.sv
// TileLink-C manager probe engine: fans a Probe out on B to a client subset, collects
// ProbeAck/ProbeAckData on C, forwards dirty beats to writeback and reports round completion.
module tl_probe_engine #(
  parameter int N_CLIENTS   = 2,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int BLOCK_BYTES = 64,
  parameter int SRC_W       = 4,
  localparam int BEATS      = BLOCK_BYTES * 8 / DATA_W,
  localparam int SIZE       = $clog2(BLOCK_BYTES),
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [ADDR_W-1:0]    req_addr_i,
  input  logic [2:0]           req_cap_i,
  input  logic [N_CLIENTS-1:0] req_mask_i,
  output logic [N_CLIENTS-1:0] tl_b_valid_o,
  input  logic [N_CLIENTS-1:0] tl_b_ready_i,
  output logic [2:0]           tl_b_opcode_o,
  output logic [2:0]           tl_b_param_o,
  output logic [3:0]           tl_b_size_o,
  output logic [ADDR_W-1:0]    tl_b_address_o,
  input  logic                 tl_c_valid_i,
  output logic                 tl_c_ready_o,
  input  logic [2:0]           tl_c_opcode_i,
  input  logic [2:0]           tl_c_param_i,
  input  logic [SRC_W-1:0]     tl_c_source_i,
  input  logic [ADDR_W-1:0]    tl_c_address_i,
  input  logic [DATA_W-1:0]    tl_c_data_i,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [DATA_W-1:0]    wb_data_o,
  output logic [BEAT_W-1:0]    wb_beat_o,
  output logic                 done_valid_o,
  input  logic                 done_ready_i,
  output logic                 done_dirty_o,
  output logic                 err_o
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [ADDR_W-1:0]      r_addr;
  logic [2:0]             r_cap;
  logic [N_CLIENTS-1:0]   r_pend_b, w_pend_b_nxt;
  logic [N_CLIENTS-1:0]   r_pend_ack, w_pend_ack_nxt;
  logic [BEAT_W-1:0]      r_beat, w_beat_nxt;
  logic                   r_dirty, w_dirty_nxt;
  logic                   r_lock_vld, w_lock_vld_nxt;
  logic [SRC_W-1:0]       r_lock_src, w_lock_src_nxt;

  logic [N_CLIENTS-1:0]   w_src_sel;
  logic                   w_active, w_req_fire;
  logic                   w_is_ack, w_is_data, w_well_formed, w_foreign;
  logic                   w_ack_ok, w_ack_stall, w_data_ok, w_bad;
  logic                   w_ack_fire, w_data_fire;
  logic                   w_unused;

  // One-hot decode of the responding source; no bit set means source is out of range.
  always_comb begin
    w_src_sel = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      w_src_sel[i] = (tl_c_source_i == SRC_W'(i));
    end
  end

  assign w_active   = (r_state == S_ACTIVE);
  assign w_req_fire = req_valid_i && (r_state == S_IDLE);
  assign w_is_ack   = (tl_c_opcode_i == 3'd4);
  assign w_is_data  = (tl_c_opcode_i == 3'd5);

  assign w_well_formed = w_active && (|(w_src_sel & r_pend_ack)) && !(|(w_src_sel & r_pend_b))
                      && (tl_c_address_i == r_addr) && (w_is_ack || w_is_data);
  assign w_foreign   = r_lock_vld && (r_lock_src != tl_c_source_i);
  assign w_ack_ok    = w_well_formed && w_is_ack && !w_foreign;
  assign w_ack_stall = w_well_formed && w_is_ack && w_foreign;
  assign w_data_ok   = w_well_formed && w_is_data && !w_foreign;
  assign w_bad       = !(w_ack_ok || w_ack_stall || w_data_ok);

  assign w_ack_fire  = tl_c_valid_i && w_ack_ok;
  assign w_data_fire = tl_c_valid_i && w_data_ok && wb_ready_i;

  assign tl_c_ready_o = tl_c_valid_i && (w_ack_ok || w_bad || (w_data_ok && wb_ready_i));
  assign err_o        = tl_c_valid_i && w_bad;
  assign wb_valid_o   = tl_c_valid_i && w_data_ok;
  assign wb_data_o    = tl_c_data_i;
  assign wb_beat_o    = r_beat;

  assign req_ready_o    = (r_state == S_IDLE);
  assign tl_b_valid_o   = w_active ? r_pend_b : '0;
  assign tl_b_opcode_o  = w_active ? 3'd6 : 3'd0;
  assign tl_b_size_o    = w_active ? 4'(SIZE) : 4'd0;
  assign tl_b_param_o   = r_cap;
  assign tl_b_address_o = r_addr;
  assign done_valid_o   = (r_state == S_DONE);
  assign done_dirty_o   = done_valid_o && r_dirty;

  assign w_unused = ^{tl_c_param_i, req_addr_i[SIZE-1:0]};

  always_comb begin
    w_state_nxt    = r_state;
    w_pend_b_nxt   = r_pend_b;
    w_pend_ack_nxt = r_pend_ack;
    w_beat_nxt     = r_beat;
    w_dirty_nxt    = r_dirty;
    w_lock_vld_nxt = r_lock_vld;
    w_lock_src_nxt = r_lock_src;
    case (r_state)
      S_IDLE: begin
        if (req_valid_i) begin
          w_pend_b_nxt   = req_mask_i;
          w_pend_ack_nxt = req_mask_i;
          w_dirty_nxt    = 1'b0;
          w_state_nxt    = (req_mask_i == '0) ? S_DONE : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        w_pend_b_nxt = r_pend_b & ~tl_b_ready_i;
        // A ProbeAck can only pass while locked if it comes from the lock owner; free the lock.
        if (w_ack_fire) begin
          w_pend_ack_nxt = r_pend_ack & ~w_src_sel;
          w_lock_vld_nxt = 1'b0;
          w_beat_nxt     = '0;
        end
        if (w_data_fire) begin
          if (r_beat == LAST_BEAT) begin
            w_pend_ack_nxt = r_pend_ack & ~w_src_sel;
            w_dirty_nxt    = 1'b1;
            w_lock_vld_nxt = 1'b0;
            w_beat_nxt     = '0;
          end else begin
            w_beat_nxt     = r_beat + BEAT_W'(1);
            w_lock_vld_nxt = 1'b1;
            w_lock_src_nxt = tl_c_source_i;
          end
        end
        if ((w_pend_b_nxt == '0) && (w_pend_ack_nxt == '0)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (done_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_cap      <= '0;
      r_pend_b   <= '0;
      r_pend_ack <= '0;
      r_beat     <= '0;
      r_dirty    <= 1'b0;
      r_lock_vld <= 1'b0;
      r_lock_src <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend_b   <= w_pend_b_nxt;
      r_pend_ack <= w_pend_ack_nxt;
      r_beat     <= w_beat_nxt;
      r_dirty    <= w_dirty_nxt;
      r_lock_vld <= w_lock_vld_nxt;
      r_lock_src <= w_lock_src_nxt;
      if (w_req_fire) begin
        r_addr <= {req_addr_i[ADDR_W-1:SIZE], {SIZE{1'b0}}};
        r_cap  <= req_cap_i;
      end
    end
  end

endmodule
